// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and stall controller for a five-stage pipeline. It detects load-use
//   hazards between ID/EX and IF/ID, resolves taken branches by flushing IF/ID,
//   and freezes the whole pipeline while data memory is not ready. Priority is
//   memory stall > load-use > branch. The lower-priority event is suppressed for
//   that cycle and is evaluated again on the next cycle that advances.
//
// Parameters
//   CNT_W     width of the saturating stall and flush event counters
//   MAX_WAIT  number of MEM_WAIT cycles at which the sticky timeout sets
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   id_rs, id_rt  source register fields of the instruction in IF/ID
//   id_uses_rt    the IF/ID instruction actually reads Rt
//   ex_memread    the ID/EX instruction is a load
//   ex_rt         destination register of the ID/EX instruction
//   branch_taken  branch resolved taken in ID
//   mem_req       MEM stage is accessing data memory this cycle
//   mem_ready     data memory completes the access this cycle
//   pc_write      PC may update
//   ifid_write    IF/ID may load (0 = freeze)
//   bubble        zero the control word entering ID/EX
//   pipe_hold     ID/EX, EX/MEM and MEM/WB hold their contents
//   flush         clear IF/ID on the next edge
//   mem_timeout   sticky flag: a memory wait reached MAX_WAIT cycles
//   stall_cnt     saturating count of load-use bubbles inserted
//   flush_cnt     saturating count of flushes issued
//   state         current FSM state: 0 = RUN, 1 = MEM_WAIT
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             bubble,
  output logic             pipe_hold,
  output logic             flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  // Wait counter is just wide enough to hold MAX_WAIT.
  localparam int                WAIT_W   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  // Encodings 2 and 3 are unused; they behave as RUN and fall back to it.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_t;

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              load_use;
  logic              hold;

  assign state     = state_q;
  assign mem_stall = mem_req & ~mem_ready;

  // A load into R0 never produces a value worth waiting for.
  assign load_use = ex_memread & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // Pipeline-control outputs are combinational in state and inputs so that a
  // hazard is handled in the same cycle it is seen.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    pipe_hold  = 1'b0;
    flush      = 1'b0;

    // In MEM_WAIT the pipeline stays frozen until mem_ready, whatever mem_req
    // does; in RUN (and the unused encodings) a fresh stall freezes it.
    hold = (state_q == MEM_WAIT) ? ~mem_ready : mem_stall;

    if (hold) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end else if (branch_taken) begin
      flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q  <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
            // Sticky: once set it only clears on reset; the FSM keeps waiting.
            if (wait_cnt == WAIT_MAX - 1'b1) mem_timeout <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase

      // Event counters saturate at all-ones rather than wrapping.
      if (bubble && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (flush  && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. Two instances share one set of inputs:
//   instance a (CNT_W=2, MAX_WAIT=4) exercises counter saturation and timeout,
//   instance b (CNT_W=8, MAX_WAIT=20) the same behaviour with wider limits.
//   A behavioural model tracks "are we waiting on memory", per-instance wait
//   lengths, timeout flags and event counts as plain integers, and predicts
//   every output each cycle. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, branch_taken, mem_req, mem_ready;

  logic       pc_write_a, ifid_write_a, bubble_a, pipe_hold_a, flush_a, mem_timeout_a;
  logic [1:0] stall_cnt_a, flush_cnt_a, state_a;
  logic       pc_write_b, ifid_write_b, bubble_b, pipe_hold_b, flush_b, mem_timeout_b;
  logic [7:0] stall_cnt_b, flush_cnt_b;
  logic [1:0] state_b;

  hazard_ctrl #(.CNT_W(2), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write_a), .ifid_write(ifid_write_a), .bubble(bubble_a),
    .pipe_hold(pipe_hold_a), .flush(flush_a), .mem_timeout(mem_timeout_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .state(state_a)
  );

  hazard_ctrl #(.CNT_W(8), .MAX_WAIT(20)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .ifid_write(ifid_write_b), .bubble(bubble_b),
    .pipe_hold(pipe_hold_b), .flush(flush_b), .mem_timeout(mem_timeout_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .state(state_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int cnt_max  [2] = '{3, 255};
  int wait_max [2] = '{4, 20};
  bit m_waiting;
  int m_wait [2];
  bit m_to   [2];
  int m_sc   [2];
  int m_fc   [2];

  // Expected pipeline controls for the current cycle.
  bit e_pc, e_ifid, e_bub, e_hold, e_flush;

  task automatic model_reset();
    m_waiting = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_to[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic predict();
    bit lu;
    lu = ex_memread && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // Frozen while already waiting without ready, or on a new unready access.
    e_hold  = m_waiting ? !mem_ready : (mem_req && !mem_ready);
    e_bub   = !e_hold && lu;
    e_flush = !e_hold && !lu && branch_taken;
    e_pc    = !e_hold && !lu;
    e_ifid  = e_pc;
  endtask

  task automatic advance_model();
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (e_bub   && m_sc[k] < cnt_max[k]) m_sc[k]++;
        if (e_flush && m_fc[k] < cnt_max[k]) m_fc[k]++;
      end
      if (m_waiting) begin
        if (mem_ready) begin
          m_waiting = 1'b0;
          m_wait[0] = 0;
          m_wait[1] = 0;
        end else begin
          for (int k = 0; k < 2; k++) begin
            if (m_wait[k] < wait_max[k]) m_wait[k]++;
            if (m_wait[k] == wait_max[k]) m_to[k] = 1'b1;
          end
        end
      end else begin
        m_waiting = mem_req && !mem_ready;
      end
    end
  endtask

  task automatic check_inst(input string p, input int k,
                            input logic pcw, input logic ifw, input logic bub,
                            input logic ph, input logic fl, input logic to,
                            input logic [31:0] sc, input logic [31:0] fc,
                            input logic [1:0] st);
    check({p, ".pc_write"},    pcw, e_pc);
    check({p, ".ifid_write"},  ifw, e_ifid);
    check({p, ".bubble"},      bub, e_bub);
    check({p, ".pipe_hold"},   ph,  e_hold);
    check({p, ".flush"},       fl,  e_flush);
    check({p, ".mem_timeout"}, to,  m_to[k]);
    check({p, ".stall_cnt"},   sc,  m_sc[k]);
    check({p, ".flush_cnt"},   fc,  m_fc[k]);
    check({p, ".state"},       st,  {1'b0, m_waiting});
  endtask

  // One cycle: drive at the falling edge, compare just after, then advance the
  // model to account for the coming rising edge.
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic [4:0] ert,
                      input logic br, input logic rq, input logic rdy);
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr;
    ex_rt = ert; branch_taken = br; mem_req = rq; mem_ready = rdy;
    #1;
    predict();
    check_inst("a", 0, pc_write_a, ifid_write_a, bubble_a, pipe_hold_a, flush_a,
               mem_timeout_a, 32'(stall_cnt_a), 32'(flush_cnt_a), state_a);
    check_inst("b", 1, pc_write_b, ifid_write_b, bubble_b, pipe_hold_b, flush_b,
               mem_timeout_b, 32'(stall_cnt_b), 32'(flush_cnt_b), state_b);
    advance_model();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  int ready_pct;

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    ex_rt = '0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    model_reset();

    // Reset, then the first free-running cycle.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("rst_pc_write",  pc_write_a,  1'b1);
    check("rst_ifid",      ifid_write_a, 1'b1);
    check("rst_pipe_hold", pipe_hold_a, 1'b0);
    check("rst_state",     state_a,     2'd0);
    check("rst_stall_cnt", stall_cnt_a, 2'd0);

    // Load-use on Rs.
    step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    check("lu_pc_write", pc_write_a, 1'b0);
    check("lu_bubble",   bubble_a,   1'b1);
    idle();
    check("lu_stall_cnt", stall_cnt_a, 2'd1);

    // R0 never stalls; Rt match ignored when Rt is not read.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("r0_bubble", bubble_a, 1'b0);
    step(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    check("rt_unused_bubble", bubble_a,   1'b0);
    check("rt_unused_pc",     pc_write_a, 1'b1);

    // Branch alone, then branch suppressed by load-use.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("br_flush", flush_a,    1'b1);
    check("br_pc",    pc_write_a, 1'b1);
    idle();
    check("br_flush_cnt", flush_cnt_a, 2'd1);
    step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    check("br_lu_bubble", bubble_a, 1'b1);
    check("br_lu_flush",  flush_a,  1'b0);
    idle();
    check("br_lu_flush_cnt", flush_cnt_a, 2'd1);

    // Memory wait: three unready cycles, then a ready cycle.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("mw_hold",  pipe_hold_a, 1'b1);
      check("mw_state", state_a, (i == 0) ? 2'd0 : 2'd1);
    end
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("mw_ready_state", state_a,     2'd1);
    check("mw_ready_hold",  pipe_hold_a, 1'b0);
    idle();
    check("mw_back_run", state_a, 2'd0);

    // Timeout on instance a after its fourth wait cycle.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("to_not_yet", mem_timeout_a, 1'b0);
    end
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("to_set",        mem_timeout_a, 1'b1);
    check("to_still_wait", state_a,       2'd1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    check("to_sticky",   mem_timeout_a, 1'b1);
    check("to_b_clear",  mem_timeout_b, 1'b0);

    // Reset in the middle of a wait, with a branch pending.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle();
    check("rstw_state",   state_a,       2'd0);
    check("rstw_timeout", mem_timeout_a, 1'b0);
    check("rstw_flush",   flush_cnt_a,   2'd0);
    check("rstw_stall",   stall_cnt_a,   2'd0);

    // Five load-use stalls saturate the 2-bit counter.
    for (int i = 0; i < 5; i++)
      step(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    idle();
    check("sat_stall_a", stall_cnt_a, 2'd3);
    check("sat_stall_b", stall_cnt_b, 8'd5);

    // Random traffic with phases of slow and fast memory.
    ready_pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       ready_pct = 5;
          1:       ready_pct = 50;
          default: ready_pct = 90;
        endcase
      end
      step(($urandom_range(0, 299) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 40),
           5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < ready_pct));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
